// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the 512-bit AXI read-port arbiter.
package rd_arb_pkg;

    // Default requester count; sizes the grant index type.
    localparam int N_REQ_DEF = 4;

    // Width of the AXI read-data bus.
    localparam int AXI_DW = 512;

    // Grant index for the default requester count.
    typedef logic [$clog2(N_REQ_DEF)-1:0] gnt_t;

    // Address-phase FSM states.
    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rd_tag_fifo.sv
// Show-ahead tag FIFO recording the grant order of outstanding read bursts.
// Stores the requester index of each issued burst. The head entry is valid
// whenever the FIFO is not empty.
module rd_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                   axi_clk,
    input  logic                   i_arst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when a pop happens alongside it.
    assign w_push = push & (~full | pop);
    assign w_pop  = pop & ~empty;

    // Write tag storage.
    // NOTE: storage is left unreset; entries are only read after a push,
    // so clearing them would just add reset fan-out.
    always_ff @(posedge axi_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Advance pointers and track occupancy.
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before the edge, independent of statement order.
    always_ff @(posedge axi_clk or posedge i_arst) begin
        if (i_arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign count = r_count;

endmodule

// File: rtl/rd_arbiter_512.sv
// Round-robin arbiter sharing one 512-bit AXI read port among N_REQ readers.
// The address phase grants one reader at a time. A tag FIFO remembers the
// grant order so returning R beats are steered, in order, to the reader that
// issued each burst. Address and data phases of different bursts overlap.
module rd_arbiter_512
    import rd_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int OUTSTD = 4
) (
    input  logic                    axi_clk,
    input  logic                    i_arst,
    input  logic [N_REQ-1:0]        s_ar_valid,
    input  logic [N_REQ*ADDR_W-1:0] s_ar_addr,
    input  logic [N_REQ*LEN_W-1:0]  s_ar_len,
    output logic [N_REQ-1:0]        s_ar_ready,
    output logic [N_REQ-1:0]        s_r_valid,
    input  logic [N_REQ-1:0]        s_r_ready,
    output logic [AXI_DW-1:0]       s_r_data,
    output logic                    s_r_last,
    output logic                    m_ar_valid,
    output logic [ADDR_W-1:0]       m_ar_addr,
    output logic [LEN_W-1:0]        m_ar_len,
    input  logic                    m_ar_ready,
    input  logic                    m_r_valid,
    input  logic [AXI_DW-1:0]       m_r_data,
    input  logic                    m_r_last,
    output logic                    m_r_ready
);

    localparam int GNT_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(OUTSTD) + 1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [GNT_W-1:0]  r_ptr;
    logic [GNT_W-1:0]  r_gnt;
    logic              r_m_ar_valid;
    logic [ADDR_W-1:0] r_m_ar_addr;
    logic [LEN_W-1:0]  r_m_ar_len;
    logic [N_REQ-1:0]  r_s_ar_ready;

    logic [GNT_W-1:0]  w_scan;
    logic [GNT_W-1:0]  w_pick_idx;
    logic              w_pick_found;
    logic              w_room;
    logic              w_grant;
    logic              w_issue_done;
    logic [GNT_W-1:0]  w_ptr_nxt;

    logic [GNT_W-1:0]  w_head;
    logic              w_tag_empty;
    logic              w_tag_full;
    logic [CNT_W-1:0]  w_tag_count;
    logic              w_m_r_ready;
    logic              w_pop;

    // Round-robin search: walk from r_ptr downwards in priority so the first
    // valid requester at or after r_ptr (with wrap) is the one left selected.
    // NOTE: every signal gets a default before the loop, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_scan       = '0;
        w_pick_idx   = '0;
        w_pick_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_scan = GNT_W'((int'(r_ptr) + k) % N_REQ);
            if (s_ar_valid[w_scan]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan;
            end
        end
    end

    // Either view of occupancy blocks a grant once OUTSTD bursts are in flight.
    assign w_room    = ~w_tag_full & (w_tag_count < CNT_W'(OUTSTD));
    assign w_ptr_nxt = (r_gnt == GNT_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

    // Address FSM state register.
    always_ff @(posedge axi_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_pick_found && w_room) w_state_nxt = ISSUE;
            ISSUE:   if (r_m_ar_valid && m_ar_ready) w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    // Address FSM output decode: grant in ARB, handshake completion in ISSUE.
    always_comb begin
        w_grant      = 1'b0;
        w_issue_done = 1'b0;
        case (r_state)
            ARB:     w_grant      = w_pick_found & w_room;
            ISSUE:   w_issue_done = r_m_ar_valid & m_ar_ready;
            default: ;
        endcase
    end

    // Registered address channel, accept pulse, grant index and RR pointer.
    always_ff @(posedge axi_clk or posedge i_arst) begin
        if (i_arst) begin
            r_m_ar_valid <= 1'b0;
            r_m_ar_addr  <= '0;
            r_m_ar_len   <= '0;
            r_s_ar_ready <= '0;
            r_gnt        <= '0;
            r_ptr        <= '0;
        end else begin
            r_s_ar_ready <= '0;
            if (w_grant) begin
                r_m_ar_valid <= 1'b1;
                r_m_ar_addr  <= s_ar_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                r_m_ar_len   <= s_ar_len[int'(w_pick_idx)*LEN_W +: LEN_W];
                r_gnt        <= w_pick_idx;
                r_s_ar_ready <= N_REQ'(1) << w_pick_idx;
            end
            if (w_issue_done) begin
                r_m_ar_valid <= 1'b0;
                r_ptr        <= w_ptr_nxt;
            end
        end
    end

    assign m_ar_valid = r_m_ar_valid;
    assign m_ar_addr  = r_m_ar_addr;
    assign m_ar_len   = r_m_ar_len;
    assign s_ar_ready = r_s_ar_ready;

    // R path is purely combinational. Beats arriving with no tag outstanding
    // are a protocol error and are held off rather than dropped.
    assign w_m_r_ready = ~w_tag_empty & s_r_ready[w_head];
    assign m_r_ready   = w_m_r_ready;
    assign s_r_valid   = (m_r_valid & ~w_tag_empty) ? (N_REQ'(1) << w_head) : '0;
    assign s_r_data    = m_r_data;
    assign s_r_last    = m_r_last;
    assign w_pop       = m_r_valid & w_m_r_ready & m_r_last;

    rd_tag_fifo #(
        .W     (GNT_W),
        .DEPTH (OUTSTD)
    ) u_tag_fifo (
        .axi_clk (axi_clk),
        .i_arst  (i_arst),
        .push    (w_issue_done),
        .pop     (w_pop),
        .din     (r_gnt),
        .head    (w_head),
        .empty   (w_tag_empty),
        .full    (w_tag_full),
        .count   (w_tag_count)
    );

endmodule

// File: tb/tb_rd_arbiter_512.sv
// Self-checking bench for rd_arbiter_512 (N_REQ=4, OUTSTD=4).
module tb_rd_arbiter_512;
    import rd_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int OS = 4;

    logic              axi_clk = 1'b0;
    logic              i_arst  = 1'b1;
    logic [N-1:0]      s_ar_valid = '0;
    logic [N*AW-1:0]   s_ar_addr  = '0;
    logic [N*LW-1:0]   s_ar_len   = '0;
    logic [N-1:0]      s_ar_ready;
    logic [N-1:0]      s_r_valid;
    logic [N-1:0]      s_r_ready  = '0;
    logic [AXI_DW-1:0] s_r_data;
    logic              s_r_last;
    logic              m_ar_valid;
    logic [AW-1:0]     m_ar_addr;
    logic [LW-1:0]     m_ar_len;
    logic              m_ar_ready = 1'b0;
    logic              m_r_valid  = 1'b0;
    logic [AXI_DW-1:0] m_r_data   = '0;
    logic              m_r_last   = 1'b0;
    logic              m_r_ready;

    rd_arbiter_512 #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW), .OUTSTD(OS)) dut (
        .axi_clk    (axi_clk),
        .i_arst     (i_arst),
        .s_ar_valid (s_ar_valid),
        .s_ar_addr  (s_ar_addr),
        .s_ar_len   (s_ar_len),
        .s_ar_ready (s_ar_ready),
        .s_r_valid  (s_r_valid),
        .s_r_ready  (s_r_ready),
        .s_r_data   (s_r_data),
        .s_r_last   (s_r_last),
        .m_ar_valid (m_ar_valid),
        .m_ar_addr  (m_ar_addr),
        .m_ar_len   (m_ar_len),
        .m_ar_ready (m_ar_ready),
        .m_r_valid  (m_r_valid),
        .m_r_data   (m_r_data),
        .m_r_last   (m_r_last),
        .m_r_ready  (m_r_ready)
    );

    always #5 axi_clk = ~axi_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ar_hs = 0;

    // Expected grants, pushed when requests are driven, popped on s_ar_ready.
    typedef struct {
        gnt_t        idx;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;
    ar_exp_t sb_q[$];
    ar_exp_t mon_e;
    logic [N-1:0] prev_rdy = '0;

    // R-path vectors applied with head tag = 2.
    typedef struct {
        logic       mv;
        logic [3:0] srr;
        logic [3:0] exp_sv;
        logic       exp_mr;
    } rvec_t;
    rvec_t rtab[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
        s_ar_valid[i]          = 1'b1;
        s_ar_addr[i*AW +: AW]  = a;
        s_ar_len[i*LW +: LW]   = l;
    endtask

    task automatic expect_grant(input int i, input logic [31:0] a, input logic [7:0] l);
        ar_exp_t e;
        e.idx  = gnt_t'(i);
        e.addr = a;
        e.len  = l;
        sb_q.push_back(e);
    endtask

    task automatic wait_pulse(input int i, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!s_ar_ready[i] && n < 20);
        check(nm, 64'(s_ar_ready[i]), 64'd1);
    endtask

    task automatic do_reset();
        i_arst = 1'b1;
        tick();
        tick();
        i_arst = 1'b0;
    endtask

    // Grant monitor: one-cycle pulse, scoreboard order and latched address.
    always @(negedge axi_clk) begin
        if (!i_arst) begin
            if (m_ar_valid && m_ar_ready) n_ar_hs++;
            if (s_ar_ready != '0) begin
                check("ar_ready_pulse", 64'(s_ar_ready & prev_rdy), 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_grant", 64'(s_ar_ready), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("grant_onehot", 64'(s_ar_ready), 64'(4'b0001 << mon_e.idx));
                    check("grant_addr", 64'(m_ar_addr), 64'(mon_e.addr));
                    check("grant_len", 64'(m_ar_len), 64'(mon_e.len));
                end
            end
            prev_rdy = s_ar_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp_d;
        logic [3:0]  r2_pat;
        logic [3:0]  last_pat;
        int          n;

        rtab[0] = '{mv: 1'b0, srr: 4'b0100, exp_sv: 4'b0000, exp_mr: 1'b1};
        rtab[1] = '{mv: 1'b1, srr: 4'b0100, exp_sv: 4'b0100, exp_mr: 1'b1};
        rtab[2] = '{mv: 1'b1, srr: 4'b1011, exp_sv: 4'b0100, exp_mr: 1'b0};
        rtab[3] = '{mv: 1'b1, srr: 4'b1111, exp_sv: 4'b0100, exp_mr: 1'b1};
        rtab[4] = '{mv: 1'b0, srr: 4'b0000, exp_sv: 4'b0000, exp_mr: 1'b0};
        rtab[5] = '{mv: 1'b1, srr: 4'b0001, exp_sv: 4'b0100, exp_mr: 1'b0};

        // ---- Reset values, and R beats with nothing outstanding ----
        tick();
        check("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check("rst_m_ar_addr", 64'(m_ar_addr), 64'd0);
        check("rst_m_ar_len", 64'(m_ar_len), 64'd0);
        check("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
        i_arst = 1'b0;
        m_r_valid = 1'b1;
        s_r_ready = 4'b1111;
        #1;
        check("empty_m_r_ready", 64'(m_r_ready), 64'd0);
        check("empty_s_r_valid", 64'(s_r_valid), 64'd0);
        tick();
        m_r_valid = 1'b0;
        check("empty_count", 64'(dut.w_tag_count), 64'd0);

        // ---- Single requester, 8-beat burst ----
        m_ar_ready = 1'b1;
        set_req(1, 32'h0010_0000, 8'd7);
        expect_grant(1, 32'h0010_0000, 8'd7);
        tick();
        check("single_ar_valid", 64'(m_ar_valid), 64'd1);
        check("single_ar_addr", 64'(m_ar_addr), 64'h0010_0000);
        check("single_ar_len", 64'(m_ar_len), 64'd7);
        s_ar_valid[1] = 1'b0;
        tick();
        check("single_ar_drop", 64'(m_ar_valid), 64'd0);
        check("single_count", 64'(dut.w_tag_count), 64'd1);
        for (int b = 0; b < 8; b++) begin
            exp_d     = 64'hA5A5_0000_0000_0000 | 64'(b);
            m_r_valid = 1'b1;
            m_r_last  = (b == 7);
            m_r_data  = {8{exp_d}};
            #1;
            check("beat_s_r_valid", 64'(s_r_valid), 64'h2);
            check("beat_m_r_ready", 64'(m_r_ready), 64'd1);
            check("beat_data_lo", s_r_data[63:0], exp_d);
            check("beat_data_hi", s_r_data[511:448], exp_d);
            check("beat_last", 64'(s_r_last), 64'(b == 7));
            check("beat_no_early_pop", 64'(dut.w_tag_count), 64'd1);
            tick();
        end
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        check("single_popped", 64'(dut.w_tag_count), 64'd0);

        // ---- All four requesting: order 0,1,2,3 then FIFO full, then 0 ----
        do_reset();
        n_ar_hs    = 0;
        m_ar_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 32'h1000_0000 + 32'(i * 256), 8'(i + 1));
        for (int i = 0; i < N; i++) expect_grant(i, 32'h1000_0000 + 32'(i * 256), 8'(i + 1));
        expect_grant(0, 32'h1000_0000, 8'd1);
        repeat (20) tick();
        check("full_hs_count", 64'(n_ar_hs), 64'd4);
        check("full_ar_valid", 64'(m_ar_valid), 64'd0);
        check("full_count", 64'(dut.w_tag_count), 64'd4);
        check("full_sb_left", 64'(sb_q.size()), 64'd1);
        m_r_valid = 1'b1;
        m_r_last  = 1'b1;
        s_r_ready = 4'b1111;
        #1;
        check("full_pop_steer", 64'(s_r_valid), 64'h1);
        tick();
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        n = 0;
        while (!m_ar_valid && n < 10) begin
            tick();
            n++;
        end
        check("fifth_ar_valid", 64'(m_ar_valid), 64'd1);
        s_ar_valid = '0;
        tick();
        tick();
        check("fifth_hs_count", 64'(n_ar_hs), 64'd5);
        check("fifth_sb_empty", 64'(sb_q.size()), 64'd0);

        // ---- Address backpressure for 10 cycles ----
        do_reset();
        m_ar_ready = 1'b0;
        set_req(1, 32'h2000_0040, 8'd15);
        set_req(3, 32'h3000_0080, 8'd3);
        expect_grant(1, 32'h2000_0040, 8'd15);
        tick();
        check("bp_grant", 64'(m_ar_valid), 64'd1);
        s_ar_valid[1] = 1'b0;
        repeat (10) begin
            tick();
            check("bp_valid", 64'(m_ar_valid), 64'd1);
            check("bp_addr", 64'(m_ar_addr), 64'h2000_0040);
            check("bp_len", 64'(m_ar_len), 64'd15);
            check("bp_no_ready", 64'(s_ar_ready), 64'd0);
        end
        expect_grant(3, 32'h3000_0080, 8'd3);
        m_ar_ready = 1'b1;
        wait_pulse(3, "bp_second_grant");
        s_ar_valid[3] = 1'b0;
        tick();
        check("bp_count", 64'(dut.w_tag_count), 64'd2);

        // ---- R steering with tags [2,0], stall and concurrent push/pop ----
        do_reset();
        m_ar_ready = 1'b1;
        set_req(2, 32'h5000_0000, 8'd2);
        expect_grant(2, 32'h5000_0000, 8'd2);
        wait_pulse(2, "steer_grant2");
        s_ar_valid[2] = 1'b0;
        set_req(0, 32'h6000_0000, 8'd0);
        expect_grant(0, 32'h6000_0000, 8'd0);
        wait_pulse(0, "steer_grant0");
        s_ar_valid[0] = 1'b0;
        tick();
        check("steer_count", 64'(dut.w_tag_count), 64'd2);
        for (int v = 0; v < 6; v++) begin
            m_r_valid = rtab[v].mv;
            m_r_last  = 1'b0;
            s_r_ready = rtab[v].srr;
            #1;
            check("tab_s_r_valid", 64'(s_r_valid), 64'(rtab[v].exp_sv));
            check("tab_m_r_ready", 64'(m_r_ready), 64'(rtab[v].exp_mr));
        end
        m_r_valid  = 1'b0;
        m_ar_ready = 1'b0;
        set_req(1, 32'h4000_0000, 8'd0);
        expect_grant(1, 32'h4000_0000, 8'd0);
        wait_pulse(1, "steer_grant1");
        s_ar_valid[1] = 1'b0;
        r2_pat   = 4'b1101;
        last_pat = 4'b1000;
        for (int b = 0; b < 4; b++) begin
            m_r_valid  = 1'b1;
            s_r_ready  = 4'b0001 | (4'(r2_pat[b]) << 2);
            m_r_last   = last_pat[b];
            m_ar_ready = (b == 3);
            #1;
            check("stall_m_r_ready", 64'(m_r_ready), 64'(r2_pat[b]));
            check("stall_s_r_valid", 64'(s_r_valid), 64'h4);
            check("stall_count", 64'(dut.w_tag_count), 64'd2);
            tick();
        end
        m_r_valid  = 1'b0;
        m_r_last   = 1'b0;
        m_ar_ready = 1'b0;
        check("pushpop_count", 64'(dut.w_tag_count), 64'd2);
        check("pushpop_ar_valid", 64'(m_ar_valid), 64'd0);
        m_r_valid = 1'b1;
        #1;
        check("next_head_steer", 64'(s_r_valid), 64'h1);

        // ---- Asynchronous reset with tags outstanding and AR pending ----
        m_r_valid = 1'b0;
        s_r_ready = 4'b1111;
        set_req(3, 32'h7000_0000, 8'd9);
        expect_grant(3, 32'h7000_0000, 8'd9);
        wait_pulse(3, "arst_grant3");
        s_ar_valid[3] = 1'b0;
        tick();
        m_r_valid = 1'b1;
        #1;
        check("pre_arst_m_r_ready", 64'(m_r_ready), 64'd1);
        check("pre_arst_ar_valid", 64'(m_ar_valid), 64'd1);
        #1;
        i_arst = 1'b1;
        #1;
        check("arst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check("arst_m_ar_addr", 64'(m_ar_addr), 64'd0);
        check("arst_m_ar_len", 64'(m_ar_len), 64'd0);
        check("arst_s_ar_ready", 64'(s_ar_ready), 64'd0);
        check("arst_m_r_ready", 64'(m_r_ready), 64'd0);
        check("arst_s_r_valid", 64'(s_r_valid), 64'd0);
        check("arst_count", 64'(dut.w_tag_count), 64'd0);
        tick();
        i_arst    = 1'b0;
        m_r_valid = 1'b0;
        tick();
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
